uart_wb_master: RTL
===================

UART_WB_MASTER -- requirements
Module: uart_wb_master

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 16, giving the maximum number of bus cycles to wait for WB_ACK_I (range 2..255).
REQ-002 The block SHALL have parameter SEL_VALUE, default 4'b0001, giving the constant byte-select driven on WB_SEL_O during a cycle.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset: clock (input, 1) is the single clock, and all logic samples on its rising edge.
REQ-004 The block SHALL have port WB_RST_I, input, 1 bit: the synchronous, active-high reset.
REQ-005 The block SHALL have the command ports cmd_valid (in, 1), cmd_ready (out, 1), cmd_we (in, 1: 1 = write), cmd_addr (in, 3) and cmd_wdata (in, 8).
REQ-006 The block SHALL have the response ports rsp_valid (out, 1), rsp_ready (in, 1), rsp_rdata (out, 8) and rsp_err (out, 1).
REQ-007 The block SHALL have the Wishbone master ports WB_ADDR_O (out, 3), WB_SEL_O (out, 4), WB_DAT_O (out, 8, write data to the UART) and WB_DAT_I (in, 8, read data from the UART).
REQ-008 The block SHALL have the Wishbone control ports WB_WE_O (out, 1), WB_STB_O (out, 1), WB_CYC_O (out, 1) and WB_ACK_I (in, 1).
REQ-009 The block SHALL have ports INT_I (in, 1, the UART IN_O output) and irq_o (out, 1, the registered interrupt).

Function
REQ-010 The block SHALL implement the FSM states IDLE, BUS and RESP, with every Wishbone and response output driven from a register.
REQ-011 cmd_ready SHALL be 1 only in IDLE; a command is accepted on an edge where cmd_valid and cmd_ready are both 1.
REQ-012 On acceptance the block SHALL latch cmd_we, cmd_addr and cmd_wdata, go to BUS, and assert WB_CYC_O and WB_STB_O in the next cycle.
REQ-013 In BUS the block SHALL hold WB_ADDR_O, WB_DAT_O, WB_WE_O and WB_SEL_O = SEL_VALUE stable; outside BUS these outputs SHALL be 0.
REQ-014 On the edge where WB_ACK_I = 1 in BUS, the block SHALL:
- deassert CYC/STB for the next cycle;
- capture rsp_rdata = WB_DAT_I for a read, or 0 for a write;
- set rsp_err = 0;
- assert rsp_valid;
- enter RESP.
REQ-015 The minimum latency SHALL be: accept at edge N, CYC/STB high from N+1, ACK sampled at N+1 gives rsp_valid high from N+2.
REQ-016 In RESP the block SHALL hold rsp_valid, rsp_rdata and rsp_err stable until rsp_ready = 1, then clear rsp_valid and return to IDLE.
REQ-017 The block SHALL ignore WB_ACK_I in IDLE and RESP.
REQ-018 The block SHALL perform no back-to-back cycles: there SHALL be at least one cycle with CYC low between consecutive transactions.
REQ-019 irq_o SHALL be INT_I registered by one flop.

Reset
REQ-020 While WB_RST_I = 1 at an edge, the FSM SHALL go to IDLE, and WB_CYC_O, WB_STB_O, WB_WE_O, WB_ADDR_O, WB_DAT_O, WB_SEL_O, rsp_valid, rsp_rdata, rsp_err, irq_o and the timeout counter SHALL all be 0.
REQ-021 Reset asserted mid-BUS or mid-RESP SHALL abort the transaction with no response produced.
REQ-022 cmd_ready SHALL be 0 during reset and 1 in the first cycle after reset is released.

Configuration
REQ-023 With macro UART_WB_TIMEOUT_EN defined:
- an 8-bit counter SHALL clear on entry to BUS and increment each BUS cycle without ACK;
- when the counter equals TIMEOUT_CYCLES-1 with no ACK, the block SHALL drop CYC/STB, set rsp_err = 1 and rsp_rdata = 0, and enter RESP.
REQ-024 With UART_WB_TIMEOUT_EN defined and ACK coinciding with the terminal count, ACK SHALL win: rsp_err = 0.
REQ-025 With UART_WB_TIMEOUT_EN undefined, the block SHALL contain no counter, SHALL wait indefinitely in BUS, and rsp_err SHALL be constant 0.

Verification
REQ-026 The bench SHALL cover a write: cmd we=1, addr=3, wdata=8'h83, ACK after 2 cycles -> WB_ADDR_O=3, WB_DAT_O=8'h83, WB_WE_O=1, SEL=4'b0001, then rsp_valid with err=0, rdata=0.
REQ-027 The bench SHALL cover a read: cmd we=0, addr=5, ACK with WB_DAT_I=8'h60 in the first BUS cycle -> rsp_valid 2 cycles after accept, rsp_rdata=8'h60.
REQ-028 The bench SHALL cover backpressure: rsp_ready held 0 for 5 cycles after a read -> rsp stable, cmd_ready=0, and a new command is not accepted until the cycle after the rsp handshake.
REQ-029 The bench SHALL cover timeout (UART_WB_TIMEOUT_EN): no ACK -> CYC high exactly 16 cycles, rsp_err=1, rsp_rdata=0; ACK in the 16th cycle -> rsp_err=0.
REQ-030 The bench SHALL cover reset mid-BUS: WB_RST_I pulsed for 1 cycle while CYC=1 -> CYC/STB 0 next cycle, no rsp_valid, cmd_ready=1 after release.
REQ-031 The bench SHALL cover the interrupt: INT_I pulsed high for 3 cycles -> irq_o high for 3 cycles, delayed by 1 cycle; a spurious ACK in IDLE -> no state change.

Source files
------------

// File: rtl/uart_wb_master.sv
// Command/response front end that runs single Wishbone cycles against a UART core.
// Define UART_WB_TIMEOUT_EN to abort cycles that see no ACK within TIMEOUT_CYCLES.
module uart_wb_master #(
  parameter int         TIMEOUT_CYCLES = 16,
  parameter logic [3:0] SEL_VALUE      = 4'b0001
) (
  input  logic       clock,
  input  logic       WB_RST_I,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_we,
  input  logic [2:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic [2:0] WB_ADDR_O,
  output logic [3:0] WB_SEL_O,
  output logic [7:0] WB_DAT_O,
  input  logic [7:0] WB_DAT_I,
  output logic       WB_WE_O,
  output logic       WB_STB_O,
  output logic       WB_CYC_O,
  input  logic       WB_ACK_I,
  input  logic       INT_I,
  output logic       irq_o
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 2..255");
  end

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t     state_q, state_d;
  logic       cyc_q, cyc_d;
  logic       we_q, we_d;
  logic [2:0] addr_q, addr_d;
  logic [7:0] dat_q, dat_d;
  logic [3:0] sel_q, sel_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] rdata_q, rdata_d;
  logic       irq_q;
  logic       bus_done;

`ifdef UART_WB_TIMEOUT_EN
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
`endif

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    addr_d      = addr_q;
    dat_d       = dat_q;
    sel_d       = sel_q;
    rsp_valid_d = rsp_valid_q;
    rdata_d     = rdata_q;
    bus_done    = 1'b0;
`ifdef UART_WB_TIMEOUT_EN
    cnt_d       = cnt_q;
    err_d       = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d = BUS;
          cyc_d   = 1'b1;
          we_d    = cmd_we;
          addr_d  = cmd_addr;
          dat_d   = cmd_wdata;
          sel_d   = SEL_VALUE;
`ifdef UART_WB_TIMEOUT_EN
          cnt_d   = 8'd0;
`endif
        end
      end
      BUS: begin
        // ACK takes priority over a coinciding terminal count
        if (WB_ACK_I) begin
          bus_done = 1'b1;
          rdata_d  = we_q ? 8'h00 : WB_DAT_I;
`ifdef UART_WB_TIMEOUT_EN
          err_d    = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          bus_done = 1'b1;
          rdata_d  = 8'h00;
          err_d    = 1'b1;
        end else begin
          cnt_d    = cnt_q + 8'd1;
`endif
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          rdata_d     = 8'h00;
`ifdef UART_WB_TIMEOUT_EN
          err_d       = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    if (bus_done) begin
      state_d     = RESP;
      cyc_d       = 1'b0;
      we_d        = 1'b0;
      addr_d      = 3'd0;
      dat_d       = 8'h00;
      sel_d       = 4'd0;
      rsp_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (WB_RST_I) begin
      state_q     <= IDLE;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 3'd0;
      dat_q       <= 8'h00;
      sel_q       <= 4'd0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= 8'h00;
      irq_q       <= 1'b0;
`ifdef UART_WB_TIMEOUT_EN
      cnt_q       <= 8'd0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      dat_q       <= dat_d;
      sel_q       <= sel_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      irq_q       <= INT_I;
`ifdef UART_WB_TIMEOUT_EN
      cnt_q       <= cnt_d;
      err_q       <= err_d;
`endif
    end
  end

  assign cmd_ready = (state_q == IDLE) && !WB_RST_I;
  assign WB_CYC_O  = cyc_q;
  assign WB_STB_O  = cyc_q;
  assign WB_WE_O   = we_q;
  assign WB_ADDR_O = addr_q;
  assign WB_DAT_O  = dat_q;
  assign WB_SEL_O  = sel_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign irq_o     = irq_q;
`ifdef UART_WB_TIMEOUT_EN
  assign rsp_err   = err_q;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule
